// File: rtl/truth_table_capture_if.sv
// ---------------------------------------------------------------------------
// truth_table_capture_if
//
// Purpose:
//   Sample handshake between a producer of observed truth-table samples and
//   the capture block. A sample is the minterm index {x,y,z} plus the
//   observed function output s; it transfers on a rising edge where both
//   in_valid and in_ready are high.
//
// Signals:
//   in_valid  producer -> capture   sample present on x, y, z, s
//   in_ready  capture  -> producer  capture block accepts a sample this cycle
//   x, y, z   producer -> capture   minterm index bits, x is the MSB
//   s         producer -> capture   observed function output for the minterm
//
// Modports:
//   master    sample producer
//   slave     capture block
// ---------------------------------------------------------------------------
interface truth_table_capture_if;
    logic in_valid;
    logic in_ready;
    logic x;
    logic y;
    logic z;
    logic s;

    modport master (
        output in_valid,
        output x,
        output y,
        output z,
        output s,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  x,
        input  y,
        input  z,
        input  s,
        output in_ready
    );
endinterface

// File: rtl/truth_table_capture.sv
// ---------------------------------------------------------------------------
// truth_table_capture
//
// Purpose:
//   Captures a 3-input truth table one minterm at a time from a stream of
//   (index, value) samples arriving in any order with any gaps. Repeated
//   samples with the same value are ignored; a repeated sample with a
//   different value flags a conflict and freezes the block in ERROR. Once
//   all eight minterms are known the block enters DONE, reports the
//   popcount of the table and, optionally, whether it matches a golden one.
//   DONE and ERROR are only left through reset or clear.
//
// Parameters:
//   EXPECTED      golden truth table, bit m is the output for minterm {x,y,z}
//
// Ports:
//   clk           single clock, rising edge
//   reset         synchronous active-high reset (wins over clear)
//   clear         synchronous capture restart, same effect as reset
//   bus           sample handshake (slave side): in_valid, in_ready, x, y, z, s
//   truth_table   captured truth table
//   seen          per-minterm captured flags
//   count         number of distinct minterms captured, 0..8
//   ones          popcount of truth_table, valid when done=1 (0 otherwise)
//   done          all eight minterms captured
//   conflict      a minterm was reported with two different values
//   mismatch      completed table differs from EXPECTED
//
// Configuration:
//   TRUTH_TABLE_CHECK_EN  when defined, the edge that sets done also sets
//                         mismatch to (final table != EXPECTED). When not
//                         defined, mismatch is constant 0 and no comparator
//                         is built.
// ---------------------------------------------------------------------------
module truth_table_capture #(
    parameter logic [7:0] EXPECTED = 8'h5D
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        clear,
    truth_table_capture_if.slave        bus,
    output logic [7:0]                  truth_table,
    output logic [7:0]                  seen,
    output logic [3:0]                  count,
    output logic [3:0]                  ones,
    output logic                        done,
    output logic                        conflict,
    output logic                        mismatch
);

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        DONE    = 2'd1,
        ERROR   = 2'd2
    } state_t;

    state_t     state;
    state_t     state_next;

    logic       restart;
    logic [2:0] index;
    logic       accept;
    logic       is_new;
    logic       is_conflict;
    logic       is_last;
    logic [7:0] table_next;
    logic [7:0] seen_next;
    logic [3:0] count_next;
    logic [3:0] ones_next;

    function automatic logic [3:0] popcount8(input logic [7:0] value);
        logic [3:0] total;
        total = 4'd0;
        for (int i = 0; i < 8; i++) begin
            total = total + {3'b000, value[i]};
        end
        return total;
    endfunction

    // reset and clear share one restart path; reset's priority over clear
    // is moot because both produce the same state.
    assign restart = reset | clear;
    assign index   = {bus.x, bus.y, bus.z};

    // Ready depends only on the state so the producer never sees a
    // combinational path from its own in_valid back to in_ready.
    assign bus.in_ready = (state == COLLECT);
    assign accept       = bus.in_valid & bus.in_ready;

    // Classify the accepted sample against what has been captured so far.
    // A duplicate with the same value falls into neither class and is a no-op.
    assign is_new      = accept & ~seen[index];
    assign is_conflict = accept & seen[index] & (truth_table[index] != bus.s);
    assign is_last     = is_new & (count == 4'd7);

    always_comb begin
        table_next = truth_table;
        seen_next  = seen;
        count_next = count;
        if (is_new) begin
            table_next[index] = bus.s;
            seen_next[index]  = 1'b1;
            count_next        = count + 4'd1;
        end
    end

    // Popcount of the table as it will be after this edge, so ones is
    // valid on the same edge that raises done.
    assign ones_next = popcount8(table_next);

    always_comb begin
        state_next = state;
        case (state)
            COLLECT: begin
                if (is_conflict) begin
                    state_next = ERROR;
                end else if (is_last) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = DONE;
            ERROR:   state_next = ERROR;
            default: state_next = COLLECT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (restart) begin
            state <= COLLECT;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (restart) begin
            truth_table <= 8'h00;
            seen        <= 8'h00;
            count       <= 4'd0;
            ones        <= 4'd0;
            done        <= 1'b0;
            conflict    <= 1'b0;
        end else begin
            truth_table <= table_next;
            seen        <= seen_next;
            count       <= count_next;
            if (is_last) begin
                ones <= ones_next;
                done <= 1'b1;
            end
            if (is_conflict) begin
                conflict <= 1'b1;
            end
        end
    end

`ifdef TRUTH_TABLE_CHECK_EN
    // Compare the completed table, including the sample landing this edge.
    always_ff @(posedge clk) begin
        if (restart) begin
            mismatch <= 1'b0;
        end else if (is_last) begin
            mismatch <= (table_next != EXPECTED);
        end
    end
`else
    // Golden table is not checked in this build; the reduction only keeps
    // the parameter referenced and folds to a constant.
    logic unused_expected;
    assign unused_expected = ^EXPECTED;
    assign mismatch        = 1'b0;
`endif

endmodule

// File: tb/tb_truth_table_capture.sv
// ---------------------------------------------------------------------------
// tb_truth_table_capture
//
// Purpose:
//   Self-checking bench for truth_table_capture. A behavioural model keeps
//   per-minterm arrays of known values and sticky done/error flags; each
//   cycle the DUT outputs are compared with that model. Directed sequences
//   cover the main scenarios, followed by randomized capture runs.
// ---------------------------------------------------------------------------
module tb_truth_table_capture;

    localparam logic [7:0] EXP = 8'h5D;

    logic       clk;
    logic       reset;
    logic       clear;
    logic [7:0] truth_table;
    logic [7:0] seen;
    logic [3:0] count;
    logic [3:0] ones;
    logic       done;
    logic       conflict;
    logic       mismatch;

    truth_table_capture_if bus();

    truth_table_capture #(
        .EXPECTED    (EXP)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .clear       (clear),
        .bus         (bus.slave),
        .truth_table (truth_table),
        .seen        (seen),
        .count       (count),
        .ones        (ones),
        .done        (done),
        .conflict    (conflict),
        .mismatch    (mismatch)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: which minterms are known and their values,
    // plus sticky outcome flags.
    bit m_seen [8];
    bit m_val  [8];
    bit m_done;
    bit m_err;
    bit m_mis;
    int m_ones;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
        end
    endtask

    function automatic logic [7:0] modelTable();
        logic [7:0] t;
        for (int i = 0; i < 8; i++) t[i] = m_seen[i] ? m_val[i] : 1'b0;
        return t;
    endfunction

    function automatic logic [7:0] modelSeen();
        logic [7:0] t;
        for (int i = 0; i < 8; i++) t[i] = m_seen[i];
        return t;
    endfunction

    function automatic int modelCount();
        int c = 0;
        for (int i = 0; i < 8; i++) c += m_seen[i];
        return c;
    endfunction

    task automatic modelReset();
        for (int i = 0; i < 8; i++) begin
            m_seen[i] = 1'b0;
            m_val[i]  = 1'b0;
        end
        m_done = 1'b0;
        m_err  = 1'b0;
        m_mis  = 1'b0;
        m_ones = 0;
    endtask

    task automatic modelStep(input bit r, input bit c, input bit v, input int m, input bit sv);
        int total;
        if (r || c) begin
            modelReset();
        end else if (v && !m_done && !m_err) begin
            if (!m_seen[m]) begin
                m_seen[m] = 1'b1;
                m_val[m]  = sv;
                if (modelCount() == 8) begin
                    m_done = 1'b1;
                    total  = 0;
                    for (int i = 0; i < 8; i++) total += m_val[i];
                    m_ones = total;
`ifdef TRUTH_TABLE_CHECK_EN
                    m_mis = (modelTable() != EXP);
`endif
                end
            end else if (m_val[m] != sv) begin
                m_err = 1'b1;
            end
        end
    endtask

    task automatic compareAll();
        checkOutput("table",    32'(truth_table), 32'(modelTable()));
        checkOutput("seen",     32'(seen),        32'(modelSeen()));
        checkOutput("count",    32'(count),       32'(modelCount()));
        checkOutput("ones",     32'(ones),        32'(m_ones));
        checkOutput("done",     32'(done),        32'(m_done));
        checkOutput("conflict", 32'(conflict),    32'(m_err));
        checkOutput("mismatch", 32'(mismatch),    32'(m_mis));
    endtask

    // One clock cycle: drive at the falling edge, check ready before the
    // rising edge, advance the model on the edge, check state afterwards.
    task automatic applyStimulus(input bit r, input bit c, input bit v, input int m, input bit sv);
        logic [2:0] idx;
        idx          = 3'(m);
        reset        = r;
        clear        = c;
        bus.in_valid = v;
        bus.x        = idx[2];
        bus.y        = idx[1];
        bus.z        = idx[0];
        bus.s        = sv;
        #1;
        checkOutput("in_ready", 32'(bus.in_ready), 32'(!m_done && !m_err));
        @(posedge clk);
        modelStep(r, c, v, m, sv);
        @(negedge clk);
        compareAll();
    endtask

    task automatic idle();
        applyStimulus(0, 0, 0, 0, 0);
    endtask

    logic [7:0] golden;
    logic [7:0] bad;

    initial begin
        reset        = 1'b1;
        clear        = 1'b0;
        bus.in_valid = 1'b0;
        bus.x        = 1'b0;
        bus.y        = 1'b0;
        bus.z        = 1'b0;
        bus.s        = 1'b0;
        modelReset();
        @(negedge clk);

        // Reset, then capture the golden table in order.
        applyStimulus(1, 0, 0, 0, 0);
        checkOutput("ready_after_reset", 32'(bus.in_ready), 32'd1);
        golden = EXP;
        for (int m = 0; m < 8; m++) applyStimulus(0, 0, 1, m, golden[m]);
        checkOutput("golden_table", 32'(truth_table), 32'h5D);
        checkOutput("golden_count", 32'(count), 32'd8);
        checkOutput("golden_ones", 32'(ones), 32'd5);
        checkOutput("golden_done", 32'(done), 32'd1);
        checkOutput("golden_mismatch", 32'(mismatch), 32'd0);
        checkOutput("golden_ready", 32'(bus.in_ready), 32'd0);
        applyStimulus(0, 0, 1, 0, ~golden[0]);

        // Same sequence with minterm 1 flipped to 1.
        applyStimulus(0, 1, 0, 0, 0);
        bad = EXP;
        bad[1] = 1'b1;
        for (int m = 0; m < 8; m++) applyStimulus(0, 0, 1, m, bad[m]);
        checkOutput("flip_table", 32'(truth_table), 32'h5F);
        checkOutput("flip_ones", 32'(ones), 32'd6);
`ifdef TRUTH_TABLE_CHECK_EN
        checkOutput("flip_mismatch", 32'(mismatch), 32'd1);
`else
        checkOutput("flip_mismatch", 32'(mismatch), 32'd0);
`endif

        // Conflict on minterm 3, inputs ignored afterwards, then clear.
        applyStimulus(0, 1, 0, 0, 0);
        applyStimulus(0, 0, 1, 3, 1);
        applyStimulus(0, 0, 1, 3, 0);
        checkOutput("conflict_flag", 32'(conflict), 32'd1);
        checkOutput("conflict_count", 32'(count), 32'd1);
        applyStimulus(0, 0, 1, 5, 1);
        applyStimulus(0, 1, 1, 6, 1);
        checkOutput("clear_count", 32'(count), 32'd0);
        checkOutput("clear_conflict", 32'(conflict), 32'd0);

        // Duplicate with the same value is harmless.
        applyStimulus(0, 0, 1, 2, 1);
        applyStimulus(0, 0, 1, 2, 1);
        checkOutput("dup_seen", 32'(seen), 32'h04);
        checkOutput("dup_count", 32'(count), 32'd1);

        // Reset mid-capture with in_valid high accepts nothing.
        applyStimulus(0, 0, 1, 0, 1);
        applyStimulus(0, 0, 1, 1, 0);
        applyStimulus(0, 0, 1, 4, 1);
        applyStimulus(1, 0, 1, 7, 1);
        checkOutput("midreset_count", 32'(count), 32'd0);
        checkOutput("midreset_seen", 32'(seen), 32'd0);
        // Reset and clear together, then clear alone with in_valid high.
        applyStimulus(1, 1, 1, 6, 1);
        applyStimulus(0, 1, 1, 6, 1);
        checkOutput("clear_blocks_accept", 32'(count), 32'd0);

        // Descending order with gaps and a duplicate; done rises only on
        // the eighth distinct minterm.
        for (int m = 7; m >= 0; m--) begin
            applyStimulus(0, 0, 1, m, golden[m]);
            if (m == 4) applyStimulus(0, 0, 1, 6, golden[6]);
            if (m % 2 == 0) idle();
            if (m == 1) checkOutput("done_not_early", 32'(done), 32'd0);
        end
        checkOutput("desc_done", 32'(done), 32'd1);

        // Randomized runs: a per-run table with occasional flipped samples,
        // gaps, and rare clear/reset pulses.
        for (int run = 0; run < 30; run++) begin
            logic [7:0] tbl;
            tbl = 8'($urandom);
            applyStimulus(1, 0, 0, 0, 0);
            for (int cyc = 0; cyc < 30; cyc++) begin
                int  m;
                bit  v, sv, r, c;
                m  = int'($urandom_range(7, 0));
                v  = ($urandom_range(3, 0) != 0);
                sv = tbl[m] ^ ($urandom_range(24, 0) == 0);
                c  = ($urandom_range(40, 0) == 0);
                r  = ($urandom_range(60, 0) == 0);
                applyStimulus(r, c, v, m, sv);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/truth_table_capture.md
TRUTH_TABLE_CAPTURE -- requirements
Module: truth_table_capture

Interface
REQ-001 Parameter EXPECTED, default 8'h5D, golden 3-input truth table; bit m is the output for minterm m={x,y,z}.
REQ-002 clk  input  1  single clock, all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 clear  input  1  synchronous restart of capture, same effect as reset on all state.
REQ-005 in_valid  input  1  sample present on x, y, z, s.
REQ-006 in_ready  output  1  block accepts a sample this cycle.
REQ-007 x, y, z  input  1 each  minterm index bits, x MSB.
REQ-008 s  input  1  observed function output for that minterm.
REQ-009 table  output  8  captured truth table.
REQ-010 seen  output  8  per-minterm captured flags.
REQ-011 count  output  4  number of distinct minterms captured, 0..8.
REQ-012 ones  output  4  popcount of table, valid when done=1.
REQ-013 done  output  1  all eight minterms captured.
REQ-014 conflict  output  1  same minterm reported with two different s values.
REQ-015 mismatch  output  1  completed table differs from EXPECTED.

Function
REQ-016 States COLLECT, DONE, ERROR; in_ready=1 only in COLLECT (combinational from state).
REQ-017 Accept = in_valid & in_ready on a rising edge; index m={x,y,z}.
REQ-018 Accept with seen[m]=0: seen[m]<=1, table[m]<=s, count<=count+1.
REQ-019 Accept with seen[m]=1 and table[m]==s: duplicate, no state change, no flag.
REQ-020 Accept with seen[m]=1 and table[m]!=s: conflict<=1, state<=ERROR, table/seen/count unchanged.
REQ-021 The edge accepting the eighth distinct minterm also sets done<=1, ones<=popcount of final table, state<=DONE (zero extra latency).
REQ-022 DONE and ERROR are sticky; in_valid ignored; exit only via reset or clear.
REQ-023 in_valid while in_ready=0 causes no change; samples are not buffered.
REQ-024 clear has priority over a simultaneous accept; reset has priority over clear.
REQ-025 count never exceeds 8; no wrap; ones and count are 4 bits to hold value 8.
REQ-026 Samples may arrive in any order, with any gaps of in_valid=0.

Reset
REQ-027 On reset or clear: state=COLLECT, table=0, seen=0, count=0, ones=0, done=0, conflict=0, mismatch=0.
REQ-028 No sample is accepted on a cycle where reset or clear is high, including reset asserted mid-capture.
REQ-029 in_ready=1 on the first cycle after reset or clear deasserts.

Configuration
REQ-030 Macro TRUTH_TABLE_CHECK_EN: when defined, the edge that sets done also sets mismatch<=(final table != EXPECTED), held until reset/clear.
REQ-031 Without TRUTH_TABLE_CHECK_EN: mismatch tied to 0, EXPECTED unused, no comparator logic; all other behaviour identical.

Verification
REQ-032 Reset, accept m=0..7 in order with s=EXPECTED[m] -> after 8th accept done=1, table=8'h5D, count=8, ones=5, mismatch=0, in_ready=0.
REQ-033 Macro on, same sequence but s=1 at m=1 -> table=8'h5F, ones=6, mismatch=1, done=1.
REQ-034 Accept m=3 s=1, then m=3 s=0 -> conflict=1, in_ready=0, count=1; further in_valid ignored; pulse clear -> all outputs 0, in_ready=1.
REQ-035 Accept m=2 s=1 twice -> count=1, seen=8'h04, conflict=0.
REQ-036 Accept four samples, assert reset with in_valid=1 -> next cycle count=0, table=0, seen=0; no accept during reset cycle.
REQ-037 Accept m=7..0 with in_valid gaps and one duplicate -> done rises exactly on the edge of the eighth distinct minterm, not before.
